// File: rtl/vec_seq_pkg.sv
// rtl/vec_seq_pkg.sv - shared types, default widths and width helper for the vec_seq run controller
package vec_seq_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ELEMS   = 8;
  localparam int DEF_NUM_OPS = 2;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_INPUT   = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DISPLAY = 2'd3
  } state_t;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// rtl/seq_watchdog.sv - compute-phase cycle counter that flags expiry at TIMEOUT-1
module seq_watchdog
  import vec_seq_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = clog2_min1(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LAST so a stalled controller never wraps back into a false window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != LAST))
      count <= count + 1'b1;
  end

  assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/vec_seq_controller.sv
// rtl/vec_seq_controller.sv - operand entry, compute hand-off with watchdog, and result display sequencer
module vec_seq_controller
  import vec_seq_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ELEMS   = DEF_ELEMS,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int OP_W   = clog2_min1(NUM_OPS),
  localparam int EL_W   = clog2_min1(ELEMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_value_ready,
  input  logic              restart,
  input  logic              comp_done,
  input  logic [DATA_W-1:0] comp_result,
  output logic              input_enable,
  output logic [ADDR_W-1:0] ctrl_mem_addr,
  output logic              ctrl_mem_wr,
  output logic [OP_W-1:0]   op_sel,
  output logic              mode_compute,
  output logic              comp_start,
  output logic              display_enable,
  output logic [DATA_W-1:0] display_value,
  output logic              error
);

  localparam logic [ADDR_W-1:0] ELEMS_A  = ADDR_W'(ELEMS);
  localparam logic [EL_W-1:0]   LAST_EL  = EL_W'(ELEMS - 1);
  localparam logic [OP_W-1:0]   LAST_OP  = OP_W'(NUM_OPS - 1);

  state_t            state, state_n;
  logic [EL_W-1:0]   elem_idx, elem_n;
  logic [OP_W-1:0]   op_n;
  logic [ADDR_W-1:0] addr_n, addr_calc;
  logic              wr_n, in_en_n, mode_n, start_n, disp_en_n, err_n;
  logic [DATA_W-1:0] disp_val_n;
  logic              wd_expired;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (restart || (state != ST_COMPUTE)),
    .enable  (state == ST_COMPUTE),
    .expired (wd_expired)
  );

  assign addr_calc = ADDR_W'(op_sel) * ELEMS_A + ADDR_W'(elem_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_INPUT;
      elem_idx       <= '0;
      op_sel         <= '0;
      ctrl_mem_addr  <= '0;
      ctrl_mem_wr    <= 1'b0;
      input_enable   <= 1'b1;
      mode_compute   <= 1'b0;
      comp_start     <= 1'b0;
      display_enable <= 1'b0;
      display_value  <= '0;
      error          <= 1'b0;
    end else begin
      state          <= state_n;
      elem_idx       <= elem_n;
      op_sel         <= op_n;
      ctrl_mem_addr  <= addr_n;
      ctrl_mem_wr    <= wr_n;
      input_enable   <= in_en_n;
      mode_compute   <= mode_n;
      comp_start     <= start_n;
      display_enable <= disp_en_n;
      display_value  <= disp_val_n;
      error          <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    elem_n     = elem_idx;
    op_n       = op_sel;
    addr_n     = ctrl_mem_addr;
    wr_n       = 1'b0;
    in_en_n    = input_enable;
    mode_n     = mode_compute;
    start_n    = 1'b0;
    disp_en_n  = display_enable;
    disp_val_n = display_value;
    err_n      = error;

    if (restart) begin
      state_n   = ST_INPUT;
      elem_n    = '0;
      op_n      = '0;
      in_en_n   = 1'b1;
      mode_n    = 1'b0;
      disp_en_n = 1'b0;
      err_n     = 1'b0;
    end else begin
      unique case (state)
        ST_INPUT: begin
          in_en_n = 1'b1;
          mode_n  = 1'b0;
          if (input_value_ready) begin
            addr_n = addr_calc;
            wr_n   = 1'b1;
            if (elem_idx == LAST_EL) begin
              elem_n = '0;
              if (op_sel == LAST_OP) begin
                op_n    = '0;
                in_en_n = 1'b0;
                state_n = ST_SETTLE;
              end else begin
                op_n = op_sel + 1'b1;
              end
            end else begin
              elem_n = elem_idx + 1'b1;
            end
          end
        end
        // Memory stays with the input side one extra cycle so the final write lands.
        ST_SETTLE: begin
          in_en_n = 1'b0;
          mode_n  = 1'b1;
          start_n = 1'b1;
          state_n = ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (comp_done) begin
            disp_val_n = comp_result;
            mode_n     = 1'b0;
            disp_en_n  = 1'b1;
            state_n    = ST_DISPLAY;
          end else if (wd_expired) begin
            err_n      = 1'b1;
            disp_val_n = '1;
            mode_n     = 1'b0;
            disp_en_n  = 1'b1;
            state_n    = ST_DISPLAY;
          end
        end
        ST_DISPLAY: begin
          in_en_n   = 1'b0;
          disp_en_n = 1'b1;
        end
        default: state_n = ST_INPUT;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_seq_controller.sv
// tb/tb_vec_seq_controller.sv - directed self-checking bench for vec_seq_controller
module tb_vec_seq_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance A: 2 operands x 8 elements, short watchdog.
  logic       a_ready, a_restart, a_done;
  logic [7:0] a_result;
  logic       a_in_en, a_wr, a_op_sel, a_mode, a_start, a_disp_en, a_error;
  logic [3:0] a_addr;
  logic [7:0] a_disp_val;

  vec_seq_controller #(.DATA_W(8), .ELEMS(8), .NUM_OPS(2), .ADDR_W(4), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .input_value_ready(a_ready), .restart(a_restart),
    .comp_done(a_done), .comp_result(a_result), .input_enable(a_in_en),
    .ctrl_mem_addr(a_addr), .ctrl_mem_wr(a_wr), .op_sel(a_op_sel),
    .mode_compute(a_mode), .comp_start(a_start), .display_enable(a_disp_en),
    .display_value(a_disp_val), .error(a_error)
  );

  // Instance B: 3 operands x 4 elements.
  logic       b_ready, b_restart, b_done;
  logic [7:0] b_result;
  logic       b_in_en, b_wr, b_mode, b_start, b_disp_en, b_error;
  logic [1:0] b_op_sel;
  logic [3:0] b_addr;
  logic [7:0] b_disp_val;

  vec_seq_controller #(.DATA_W(8), .ELEMS(4), .NUM_OPS(3), .ADDR_W(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .input_value_ready(b_ready), .restart(b_restart),
    .comp_done(b_done), .comp_result(b_result), .input_enable(b_in_en),
    .ctrl_mem_addr(b_addr), .ctrl_mem_wr(b_wr), .op_sel(b_op_sel),
    .mode_compute(b_mode), .comp_start(b_start), .display_enable(b_disp_en),
    .display_value(b_disp_val), .error(b_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feeds n back-to-back elements to A, checking operand select, strobe and address.
  task automatic feed_a(input int n);
    for (int i = 0; i < n; i++) begin
      chk("a_op_sel", {31'd0, a_op_sel}, i / 8);
      a_ready = 1'b1;
      tick();
      chk("a_wr", {31'd0, a_wr}, 1);
      chk("a_addr", {28'd0, a_addr}, i);
      chk("a_in_en", {31'd0, a_in_en}, (i == 15) ? 0 : 1);
    end
    a_ready = 1'b0;
  endtask

  // After the 16th element: settle cycle, then first compute cycle with the start pulse.
  task automatic enter_compute_a();
    chk("settle_mode", {31'd0, a_mode}, 0);
    chk("settle_start", {31'd0, a_start}, 0);
    tick();
    chk("compute_wr", {31'd0, a_wr}, 0);
    chk("compute_mode", {31'd0, a_mode}, 1);
    chk("compute_start", {31'd0, a_start}, 1);
  endtask

  initial begin
    rst = 1'b1;
    a_ready = 0; a_restart = 0; a_done = 0; a_result = 8'h00;
    b_ready = 0; b_restart = 0; b_done = 0; b_result = 8'h00;
    tick();
    tick();
    chk("rst_in_en", {31'd0, a_in_en}, 1);
    chk("rst_wr", {31'd0, a_wr}, 0);
    chk("rst_mode", {31'd0, a_mode}, 0);
    chk("rst_disp_en", {31'd0, a_disp_en}, 0);
    chk("rst_disp_val", {24'd0, a_disp_val}, 0);
    chk("rst_error", {31'd0, a_error}, 0);
    rst = 1'b0;
    tick();

    // Full entry, done ignored while in INPUT.
    a_done = 1'b1; a_result = 8'hEE;
    tick();
    a_done = 1'b0;
    chk("done_ignored_disp", {31'd0, a_disp_en}, 0);
    feed_a(16);
    enter_compute_a();
    tick();
    chk("start_single", {31'd0, a_start}, 0);
    chk("compute_hold", {31'd0, a_mode}, 1);

    // Normal completion.
    a_done = 1'b1; a_result = 8'h5A;
    tick();
    a_done = 1'b0;
    chk("done_disp_en", {31'd0, a_disp_en}, 1);
    chk("done_disp_val", {24'd0, a_disp_val}, 8'h5A);
    chk("done_mode", {31'd0, a_mode}, 0);
    chk("done_error", {31'd0, a_error}, 0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    chk("display_no_wr", {31'd0, a_wr}, 0);

    // Restart, partial entry, then restart coincident with ready.
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
    chk("restart_in_en", {31'd0, a_in_en}, 1);
    chk("restart_disp_en", {31'd0, a_disp_en}, 0);
    feed_a(5);
    a_ready = 1'b1; a_restart = 1'b1;
    tick();
    a_ready = 1'b0; a_restart = 1'b0;
    chk("restart_no_wr", {31'd0, a_wr}, 0);
    chk("restart_op_sel", {31'd0, a_op_sel}, 0);
    feed_a(16);
    enter_compute_a();

    // Timeout: error appears 16 cycles after the first compute cycle.
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("wd_no_error", {31'd0, a_error}, 0);
    end
    tick();
    chk("to_error", {31'd0, a_error}, 1);
    chk("to_disp_val", {24'd0, a_disp_val}, 8'hFF);
    chk("to_disp_en", {31'd0, a_disp_en}, 1);
    chk("to_mode", {31'd0, a_mode}, 0);
    a_done = 1'b1; a_result = 8'h11;
    tick();
    a_done = 1'b0;
    chk("late_done_ignored", {24'd0, a_disp_val}, 8'hFF);
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
    chk("clr_error", {31'd0, a_error}, 0);
    chk("clr_in_en", {31'd0, a_in_en}, 1);

    // Done arriving in the expiry cycle wins.
    feed_a(16);
    enter_compute_a();
    for (int k = 1; k < 16; k++) tick();
    a_done = 1'b1; a_result = 8'h3C;
    tick();
    a_done = 1'b0;
    chk("race_disp_val", {24'd0, a_disp_val}, 8'h3C);
    chk("race_error", {31'd0, a_error}, 0);
    chk("race_disp_en", {31'd0, a_disp_en}, 1);

    // Async reset mid-entry clears the pending strobe immediately.
    a_restart = 1'b1;
    tick();
    a_restart = 1'b0;
    feed_a(3);
    chk("pre_rst_wr", {31'd0, a_wr}, 1);
    rst = 1'b1;
    #1;
    chk("async_wr", {31'd0, a_wr}, 0);
    chk("async_addr", {28'd0, a_addr}, 0);
    chk("async_in_en", {31'd0, a_in_en}, 1);
    rst = 1'b0;
    feed_a(1);

    // Instance B: 3 operands of 4 elements.
    for (int i = 0; i < 12; i++) begin
      chk("b_op_sel", {30'd0, b_op_sel}, i / 4);
      b_ready = 1'b1;
      tick();
      chk("b_wr", {31'd0, b_wr}, 1);
      chk("b_addr", {28'd0, b_addr}, i);
    end
    b_ready = 1'b0;
    chk("b_settle_mode", {31'd0, b_mode}, 0);
    tick();
    chk("b_start", {31'd0, b_start}, 1);
    chk("b_mode", {31'd0, b_mode}, 1);
    b_done = 1'b1; b_result = 8'hA7;
    tick();
    b_done = 1'b0;
    chk("b_disp_val", {24'd0, b_disp_val}, 8'hA7);
    chk("b_disp_en", {31'd0, b_disp_en}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_seq_controller.md
# vec_seq_controller

Parametrised run controller for the operand-entry / compute / display flow. Accepts NUM_OPS operands of ELEMS elements each from the input stage and issues one memory write per accepted element. It then hands the memory to the compute engine with a start pulse, waits for completion under a watchdog, and latches the result for display. Adds soft restart, a compute timeout and an error flag.

## Interface
- DATA_W, 8, width of comp_result and display_value
- ELEMS, 8, elements per operand (≥2)
- NUM_OPS, 2, operands per run (≥1)
- ADDR_W, 4, memory address width; must satisfy 2^ADDR_W ≥ NUM_OPS*ELEMS
- TIMEOUT, 1024, max cycles in COMPUTE before error (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- input_value_ready  in  1  one-cycle pulse: element valid at input stage
- restart  in  1  one-cycle pulse: abandon current run, return to entry
- comp_done  in  1  compute engine completion pulse
- comp_result  in  DATA_W  result, valid with comp_done
- input_enable  out  1  input stage may accept keys
- ctrl_mem_addr  out  ADDR_W  write address
- ctrl_mem_wr  out  1  write strobe, one cycle per element
- op_sel  out  clog2(NUM_OPS) (min 1)  operand currently being entered
- mode_compute  out  1  memory owned by compute engine
- comp_start  out  1  one-cycle start pulse
- display_enable  out  1  display result valid (level)
- display_value  out  DATA_W  latched result
- error  out  1  timeout occurred this run (sticky until restart)

## Operation
- States: INPUT, SETTLE, COMPUTE, DISPLAY. Reset → INPUT, elem_idx=0, op_idx=0.
- Reset values: input_enable=1; all other outputs 0.
- All outputs registered. ctrl_mem_wr, comp_start default 0 every cycle.
- INPUT: input_enable=1, mode_compute=0. On ready: ctrl_mem_addr ← op_idx*ELEMS + elem_idx, ctrl_mem_wr=1, elem_idx++. On elem_idx=ELEMS-1: elem_idx←0, op_idx++. On last element of op NUM_OPS-1: op_idx←0, → SETTLE.
- SETTLE: exactly one cycle; input_enable=0, mode_compute stays 0 (last write completes). → COMPUTE.
- COMPUTE: mode_compute=1; comp_start=1 on first COMPUTE cycle only. Watchdog counts cycles in COMPUTE from 0.
  - comp_done: display_value ← comp_result, mode_compute←0, → DISPLAY.
  - Watchdog reaches TIMEOUT-1 without done: error←1, display_value ← all ones, mode_compute←0, → DISPLAY.
  - done and timeout same cycle: done wins, error stays 0.
- DISPLAY: display_enable=1, input_enable=0; holds until restart.
- restart (any state, highest priority after rst): → INPUT, indices 0, watchdog 0, error 0, display_enable 0, mode_compute 0, input_enable 1 next cycle; no write issued that cycle even if ready is coincident.
- comp_done outside COMPUTE ignored. input_value_ready outside INPUT ignored.

## Timing
- Ready at cycle T → ctrl_mem_wr/addr valid at T+1. Back-to-back ready every cycle supported.
- Last element ready at T: write at T+1 (state SETTLE), mode_compute=1 and comp_start=1 at T+2.
- comp_done at D: display_enable=1, display_value valid, mode_compute=0 at D+1.
- Timeout: error=1 at TIMEOUT cycles after first COMPUTE cycle.
- restart at R: input_enable=1, display_enable=0 at R+1; first new write earliest R+2.
- Async rst mid-run: outputs at reset values immediately; no partial pulse.

## Structure
- Shared package/header vec_seq_pkg: state encoding localparams, default widths, clog2 helper.
- Sub-module seq_watchdog: clear/enable counter with TIMEOUT parameter, expired output.
- Address computed as op_idx*ELEMS + elem_idx in ADDR_W bits; no wrap beyond NUM_OPS*ELEMS-1.

## Test plan
- Defaults, 16 ready pulses one per cycle → addresses 0..15 each with one ctrl_mem_wr; op_sel 0 for first 8, 1 after; comp_start single pulse 2 cycles after 16th ready.
- comp_done with comp_result=0x5A → display_value=0x5A, display_enable=1 next cycle, mode_compute=0, error=0.
- TIMEOUT=16, no comp_done → error=1 and display_value=0xFF 16 cycles after start; then restart → error=0, input_enable=1.
- restart after 5 elements → next 16 elements write addresses 0..15 again; no write on restart cycle.
- comp_done coincident with timeout expiry → display_value=comp_result, error=0.
- NUM_OPS=3, ELEMS=4, ADDR_W=4 → addresses 0..11, op_sel 0/1/2, then compute.
